// File: rtl/fp_round_pack.sv
//==============================================================================
// Module   : fp_round_pack
// Brief    : 3-stage normalize / round / pack of the FPU adder's unrounded sum
//            into an IEEE-754 double, valid/ready on both sides, global stall.
//            Optional exception flags output `exc` when FP_ROUND_EXC_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fp_round_pack #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int BIAS   = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    ss,
    input  logic [EXP_W-1:0]        es,
    input  logic [FRAC_W+4:0]       fs,
    input  logic [FRAC_W+5:0]       fls,
    input  logic [1:0]              RM,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result
`ifdef FP_ROUND_EXC_EN
    ,
    output logic [3:0]              exc
`endif
);

    localparam int c_sig_w  = FRAC_W + 4;   // hidden + fraction + guard/round/sticky
    localparam int c_man_w  = FRAC_W + 1;
    localparam int c_iexp_w = EXP_W + 2;
    localparam int c_lz_w   = $clog2(c_sig_w + 1);
    localparam int c_e_ovf  = 2 * BIAS + 1;
    localparam int c_f_zero = FRAC_W + 5;
    localparam int c_f_inf  = FRAC_W + 4;
    localparam int c_f_nan  = FRAC_W + 3;
    localparam int c_f_inv  = FRAC_W + 2;
    localparam logic [EXP_W+FRAC_W:0] c_qnan =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef struct packed {
        logic                       valid;
        logic                       sign;
        logic signed [c_iexp_w-1:0] exp;
        logic [c_sig_w-1:0]         sig;
        logic [1:0]                 rm;
        logic                       nan;
        logic                       inf;
        logic                       zero;
        logic                       zero_in;
        logic                       inv;
        logic [FRAC_W-1:0]          payload;
    } s1_t;

    typedef struct packed {
        logic                       valid;
        logic                       sign;
        logic signed [c_iexp_w-1:0] exp;
        logic [c_man_w-1:0]         man;
        logic [1:0]                 rm;
        logic                       nan;
        logic                       inf;
        logic                       zero;
        logic                       zero_in;
        logic                       inv;
        logic [FRAC_W-1:0]          payload;
        logic                       inexact;
    } s2_t;

    function automatic logic [c_lz_w-1:0] lzc(input logic [c_sig_w-1:0] v);
        logic [c_lz_w-1:0] n;
        n = c_lz_w'(c_sig_w);
        for (int i = 0; i < c_sig_w; i++)
            if (v[i]) n = c_lz_w'(c_sig_w - 1 - i);
        return n;
    endfunction

    s1_t                    s1_d, s1_q;
    s2_t                    s2_d, s2_q;
    logic                   out_valid_d, out_valid_q;
    logic [EXP_W+FRAC_W:0]  result_d, result_q;
    logic [3:0]             exc_d, exc_q;

    logic                   w_adv;
    logic [c_lz_w-1:0]      w_lz, w_shamt;
    logic [EXP_W:0]         w_es_m1, w_lz_ext;
    logic                   w_g, w_s, w_lsb, w_inc;
    logic [c_man_w:0]       w_sum;
    logic                   w_ovf, w_to_inf;
    logic [EXP_W+FRAC_W:0]  w_pack;
    logic [3:0]             w_exc;
    logic                   w_unused;

    assign w_adv     = !out_valid_q | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign w_unused  = ^fls[FRAC_W+1:FRAC_W];
`ifdef FP_ROUND_EXC_EN
    assign exc       = exc_q;
`endif

    // Normalize: left shift is capped so the exponent never drops below 1.
    always_comb begin
        w_lz     = lzc(fs[c_sig_w-1:0]);
        w_es_m1  = {1'b0, es} - (EXP_W+1)'(1);
        w_lz_ext = (EXP_W+1)'(w_lz);
        w_shamt  = (w_lz_ext > w_es_m1) ? w_es_m1[c_lz_w-1:0] : w_lz;
        s1_d     = s1_q;
        if (w_adv) begin
            s1_d.valid   = in_valid;
            s1_d.sign    = ss;
            s1_d.rm      = RM;
            s1_d.nan     = fls[c_f_nan];
            s1_d.inf     = fls[c_f_inf];
            s1_d.inv     = fls[c_f_inv];
            s1_d.zero_in = fls[c_f_zero];
            s1_d.zero    = fls[c_f_zero] | ((fs == '0) & (fls[c_f_zero:c_f_inv] == 4'b0));
            s1_d.payload = fls[FRAC_W-1:0];
            if (fs[c_sig_w]) begin
                s1_d.sig = {fs[c_sig_w:2], fs[1] | fs[0]};
                s1_d.exp = $signed(c_iexp_w'(es)) + c_iexp_w'(1);
            end else if (es == '0) begin
                s1_d.sig = fs[c_sig_w-1:0];
                s1_d.exp = c_iexp_w'(1);
            end else begin
                s1_d.sig = fs[c_sig_w-1:0] << w_shamt;
                s1_d.exp = $signed(c_iexp_w'(es)) - $signed(c_iexp_w'(w_shamt));
            end
        end
    end

    // Round: a denormal carrying into the hidden bit already sits at exponent 1.
    always_comb begin
        w_g   = s1_q.sig[2];
        w_s   = s1_q.sig[1] | s1_q.sig[0];
        w_lsb = s1_q.sig[3];
        case (s1_q.rm)
            2'b00:   w_inc = w_g & (w_s | w_lsb);
            2'b01:   w_inc = 1'b0;
            2'b10:   w_inc = !s1_q.sign & (w_g | w_s);
            default: w_inc = s1_q.sign & (w_g | w_s);
        endcase
        w_sum = {1'b0, s1_q.sig[c_sig_w-1:3]} + (c_man_w+1)'(w_inc);
        s2_d  = s2_q;
        if (w_adv) begin
            s2_d.valid   = s1_q.valid;
            s2_d.sign    = s1_q.sign;
            s2_d.rm      = s1_q.rm;
            s2_d.nan     = s1_q.nan;
            s2_d.inf     = s1_q.inf;
            s2_d.zero    = s1_q.zero;
            s2_d.zero_in = s1_q.zero_in;
            s2_d.inv     = s1_q.inv;
            s2_d.payload = s1_q.payload;
`ifdef FP_ROUND_EXC_EN
            s2_d.inexact = w_g | w_s;
`else
            s2_d.inexact = 1'b0;
`endif
            if (w_sum[c_man_w]) begin
                s2_d.man = {1'b1, {FRAC_W{1'b0}}};
                s2_d.exp = s1_q.exp + c_iexp_w'(1);
            end else begin
                s2_d.man = w_sum[c_man_w-1:0];
                s2_d.exp = s1_q.exp;
            end
        end
    end

    // Pack, highest priority first.
    always_comb begin
        w_ovf = (s2_q.exp >= c_iexp_w'(c_e_ovf));
        case (s2_q.rm)
            2'b00:   w_to_inf = 1'b1;
            2'b01:   w_to_inf = 1'b0;
            2'b10:   w_to_inf = !s2_q.sign;
            default: w_to_inf = s2_q.sign;
        endcase
        w_exc = 4'b0;
        if (s2_q.nan | s2_q.inv) begin
            w_pack = c_qnan | {{(EXP_W+1){1'b0}}, s2_q.payload};
            w_exc  = {s2_q.inv, 3'b000};
        end else if (s2_q.inf) begin
            w_pack = {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (s2_q.zero) begin
            w_pack = {s2_q.zero_in ? s2_q.sign : (s2_q.rm == 2'b11), {(EXP_W+FRAC_W){1'b0}}};
        end else if (w_ovf) begin
            w_pack = w_to_inf ? {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                              : {s2_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
            w_exc  = 4'b0101;
        end else if (!s2_q.man[FRAC_W]) begin
            w_pack = {s2_q.sign, {EXP_W{1'b0}}, s2_q.man[FRAC_W-1:0]};
            w_exc  = {2'b00, s2_q.inexact, s2_q.inexact};
        end else begin
            w_pack = {s2_q.sign, s2_q.exp[EXP_W-1:0], s2_q.man[FRAC_W-1:0]};
            w_exc  = {3'b000, s2_q.inexact};
        end
        out_valid_d = out_valid_q;
        result_d    = result_q;
        exc_d       = exc_q;
        if (w_adv) begin
            out_valid_d = s2_q.valid;
            if (s2_q.valid) begin
                result_d = w_pack;
`ifdef FP_ROUND_EXC_EN
                exc_d    = w_exc;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            exc_q       <= 4'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            exc_q       <= exc_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_round_pack.sv
//==============================================================================
// Module   : tb_fp_round_pack
// Brief    : Randomized + directed bench for fp_round_pack against a numeric
//            rounding reference model (exc checked when FP_ROUND_EXC_EN).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, ss, out_valid, out_ready;
    logic [10:0] es;
    logic [56:0] fs;
    logic [57:0] fls;
    logic [1:0]  rm;
    logic [63:0] result;
    logic [3:0]  exc;

    always #5 clk = ~clk;

    fp_round_pack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ss        (ss),
        .es        (es),
        .fs        (fs),
        .fls       (fls),
        .RM        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef FP_ROUND_EXC_EN
        ,
        .exc       (exc)
`endif
    );

`ifndef FP_ROUND_EXC_EN
    assign exc = 4'b0;
`endif

    typedef struct {
        logic [63:0] res;
        logic [3:0]  xf;
        int          acc;
        bit          lat;
    } sb_t;

    sb_t         sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          lat_mode = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_result;
    logic [3:0]  prev_exc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Exact value is fs * 2^(E-BIAS-55); round it to a 53-bit significand.
    function automatic logic [63:0] ref_model(input logic s, input logic [10:0] e_in,
                                              input logic [56:0] f, input logic [57:0] fl,
                                              input logic [1:0] mode, output logic [3:0] x);
        int           p, be, eb, k;
        logic [127:0] v, q, rem, half;
        logic         inc, inx;
        x = 4'b0;
        if (fl[55] || fl[54]) begin
            x = {fl[54], 3'b000};
            return 64'h7FF8_0000_0000_0000 | {12'h0, fl[51:0]};
        end
        if (fl[56]) return {s, 11'h7FF, 52'h0};
        if (fl[57]) return {s, 63'h0};
        if (f == 57'd0) return {(mode == 2'd3), 63'h0};
        p = 0;
        for (int i = 0; i < 57; i++) if (f[i]) p = i;
        be = f[56] ? int'(e_in) : ((e_in == 11'd0) ? 1 : int'(e_in));
        eb = be + p - 55;
        if (eb < 1) eb = 1;
        k = eb - be + 3;
        v = 128'(f);
        if (k > 0) begin
            q    = v >> k;
            rem  = v - (q << k);
            half = 128'd1 << (k - 1);
        end else begin
            q    = v << (-k);
            rem  = 128'd0;
            half = 128'd0;
        end
        inx = (rem != 128'd0);
        case (mode)
            2'd0:    inc = inx && ((rem > half) || ((rem == half) && q[0]));
            2'd1:    inc = 1'b0;
            2'd2:    inc = !s && inx;
            default: inc = s && inx;
        endcase
        q = q + 128'(inc);
        if (q[53]) begin
            q  = q >> 1;
            eb = eb + 1;
        end
        if (eb >= 2047) begin
            x = 4'b0101;
            if (mode == 2'd0 || (mode == 2'd2 && !s) || (mode == 2'd3 && s))
                return {s, 11'h7FF, 52'h0};
            return {s, 11'h7FE, {52{1'b1}}};
        end
        if (!q[52]) begin
            x = {2'b00, inx, inx};
            return {s, 11'h000, q[51:0]};
        end
        x = {3'b000, inx};
        return {s, 11'(eb), q[51:0]};
    endfunction

    // One clock: drive at negedge, observe settled outputs 1 time unit later.
    task automatic tick(input logic v, input logic s, input logic [10:0] e, input logic [56:0] f,
                        input logic [57:0] fl, input logic [1:0] mode, input logic ordy,
                        input bit use_fix, input logic [63:0] fix, output bit acc);
        sb_t         item;
        logic [3:0]  xe;
        @(negedge clk);
        in_valid  = v;
        ss        = s;
        es        = e;
        fs        = f;
        fls       = fl;
        rm        = mode;
        out_ready = ordy;
        #1;
        cyc++;
        acc = 0;
        if (rst) begin
            prev_stall = 0;
            return;
        end
        if (prev_stall) begin
            check("stall_hold_result", result, prev_result);
            check("stall_hold_exc", 64'(exc), 64'(prev_exc));
            check("stall_hold_valid", 64'(out_valid), 64'd1);
        end
        if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_output", 64'(out_valid), 64'd0);
            end else begin
                item = sb.pop_front();
                check("result", result, item.res);
`ifdef FP_ROUND_EXC_EN
                check("exc", 64'(exc), 64'(item.xf));
`endif
                if (item.lat) check("latency", 64'(cyc - item.acc), 64'd3);
            end
        end
        if (in_valid && in_ready) begin
            acc      = 1;
            item.res = ref_model(s, e, f, fl, mode, xe);
            if (use_fix) item.res = fix;
            item.xf  = xe;
            item.acc = cyc;
            item.lat = lat_mode;
            sb.push_back(item);
        end
        prev_stall  = out_valid && !out_ready;
        prev_result = result;
        prev_exc    = exc;
    endtask

    task automatic idle(input logic ordy);
        bit a;
        tick(1'b0, 1'b0, 11'd0, 57'd0, 58'd0, 2'd0, ordy, 1'b0, 64'd0, a);
    endtask

    task automatic send(input logic s, input logic [10:0] e, input logic [56:0] f,
                        input logic [57:0] fl, input logic [1:0] mode, input logic [63:0] fix);
        bit a;
        a = 0;
        for (int i = 0; i < 20 && !a; i++) tick(1'b1, s, e, f, fl, mode, 1'b1, 1'b1, fix, a);
        if (!a) check("accept_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) idle(1'b1);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [56:0] rnd_fs();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0:       return r[56:0];
            1:       return r[56:0] >> $urandom_range(0, 60);
            2:       return {r[63], 1'b1, r[54:4], r[60], 3'b100};
            3:       return {1'b0, {53{1'b1}}, r[2:0]};
            default: return {1'b0, 1'b1, r[54:0]};
        endcase
    endfunction

    function automatic logic [10:0] rnd_es();
        case ($urandom_range(0, 3))
            0:       return 11'($urandom_range(0, 70));
            1:       return 11'($urandom_range(1000, 1050));
            2:       return 11'($urandom_range(2030, 2047));
            default: return 11'($urandom_range(0, 2047));
        endcase
    endfunction

    function automatic logic [57:0] rnd_fls();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 15))
            0:       return {3'b001, r[60], 1'b0, r[52:0]};
            1:       return {4'b0001, 1'b0, r[52:0]};
            2:       return {4'b0100, 1'b0, 53'd0};
            3:       return {4'b1000, 1'b0, 53'd0};
            4:       return {2'b11, r[61], 2'b00, r[52:0]};
            default: return 58'd0;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit          a, have;
        logic        r_s, r_v, r_o;
        logic [10:0] r_e;
        logic [56:0] r_f;
        logic [57:0] r_fl;
        logic [1:0]  r_m;
        int          idx;
        logic [56:0] bp_f [5];

        rst = 1'b1;
        in_valid = 0; ss = 0; es = '0; fs = '0; fls = '0; rm = '0; out_ready = 1;
        repeat (3) idle(1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Directed beats back to back, unstalled: latency and throughput.
        lat_mode = 1;
        send(1'b0, 11'h400, {2'b11, 55'd0}, 58'd0, 2'd0, 64'h4018_0000_0000_0000);
        send(1'b0, 11'h3FF, (57'd1 << 55) | (57'd1 << 2), 58'd0, 2'd0, 64'h3FF0_0000_0000_0000);
        send(1'b0, 11'h3FF, (57'd1 << 55) | (57'd1 << 3) | (57'd1 << 2), 58'd0, 2'd0,
             64'h3FF0_0000_0000_0002);
        send(1'b0, 11'h7FE, 57'd1 << 56, 58'd0, 2'd0, 64'h7FF0_0000_0000_0000);
        send(1'b0, 11'h7FE, 57'd1 << 56, 58'd0, 2'd1, 64'h7FEF_FFFF_FFFF_FFFF);
        send(1'b0, 11'h100, 57'd1 << 55, (58'd1 << 55) | 58'h1234, 2'd0, 64'h7FF8_0000_0000_1234);
        send(1'b0, 11'h100, 57'd0, 58'd0, 2'd3, 64'h8000_0000_0000_0000);
        send(1'b0, 11'h100, 57'd0, 58'd0, 2'd0, 64'h0000_0000_0000_0000);
        drain(20);
        lat_mode = 0;

        // Backpressure: 5 beats, out_ready low on stream cycles 4..6.
        for (int i = 0; i < 5; i++) bp_f[i] = {2'b01, 55'($urandom) << 20};
        idx = 0;
        for (int j = 1; j <= 40 && !(idx == 5 && sb.size() == 0); j++) begin
            r_o = !(j >= 4 && j <= 6);
            if (idx < 5)
                tick(1'b1, 1'b0, 11'(1000 + idx), bp_f[idx], 58'd0, 2'd0, r_o, 1'b0, 64'd0, a);
            else
                tick(1'b0, 1'b0, 11'd0, 57'd0, 58'd0, 2'd0, r_o, 1'b0, 64'd0, a);
            if (a) idx++;
        end
        check("bp_all_sent", 64'(idx), 64'd5);
        check("bp_all_received", 64'(sb.size()), 64'd0);

        // Reset with two beats in flight: both are discarded.
        send(1'b0, 11'h3FF, 57'd1 << 55, 58'd0, 2'd0, 64'h3FF0_0000_0000_0000);
        send(1'b1, 11'h3FF, 57'd1 << 55, 58'd0, 2'd0, 64'hBFF0_0000_0000_0000);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", result, 64'd0);
        sb.delete();
        prev_stall = 0;
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (8) idle(1'b1);

        // Randomized traffic with random stalls and rounding modes.
        have = 0;
        r_s = 0; r_e = '0; r_f = '0; r_fl = '0; r_m = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!have) begin
                r_s  = 1'($urandom);
                r_e  = rnd_es();
                r_f  = rnd_fs();
                r_fl = rnd_fls();
                r_m  = 2'($urandom);
                have = 1;
            end
            r_v = ($urandom_range(0, 9) < 7);
            r_o = ($urandom_range(0, 9) < 8);
            tick(r_v, r_s, r_e, r_f, r_fl, r_m, r_o, 1'b0, 64'd0, a);
            if (a) have = 0;
        end
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Downstream neighbour of the FPU adder. Consumes the adder's unrounded sum `ss`/`es`/`fs` plus the special-case word `fls`, and produces a packed IEEE-754 double.
- 3-stage pipeline: normalize, round, pack.
- Valid/ready handshake on both sides; a single global stall.

Parameters:
- EXP_W, 11, exponent width. Only the default is supported; ports derive from it.
- FRAC_W, 52, fraction width. Only the default is supported; ports derive from it.
- BIAS, 1023, exponent bias, used for the overflow and denormal limits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- ss  in  1  sum sign
- es  in  11  biased sum exponent
- fs  in  57  unrounded significand: [56] carry, [55] hidden, [54:3] fraction, [2] guard, [1] round, [0] sticky
- fls  in  58  specials: [57] zero, [56] inf, [55] nan, [54] invalid, [53] reserved, [52:0] nan significand
- RM  in  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  64  packed double

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset: all stage valid bits clear; out_valid=0, result=64'h0. in_ready=1 in the first cycle after reset deasserts.
- Advance condition: adv = !out_valid | out_ready; in_ready = adv.
  - All three stages shift together when adv=1, otherwise they hold.
  - Bubbles are not collapsed.
- Handshake: a beat transfers on in_valid & in_ready.
- Latency: exactly 3 cycles from accept to out_valid when unstalled. Throughput 1 beat/cycle.
- Stage 1, normalize:
  - fs[56]=1: shift right 1, e=es+1, sticky |= shifted-out bit.
  - Otherwise: lz = leading zeros of fs[55:0]; shift left by min(lz, es-1). If es=0, no shift and treat as denormal with e=1.
  - fs all-zero with no special flag: set the internal zero flag.
  - Internal exponent is 13 bits signed. No wrap is permitted.
- Stage 2, round:
  - g = guard, s = round|sticky, lsb = fraction[0].
  - Increment rules:
    - RM=00: g & (s | lsb).
    - RM=01: none.
    - RM=10: !sign & (g|s).
    - RM=11: sign & (g|s).
  - If the increment carries to 2.0: mantissa = 1.0, exponent += 1.
  - A denormal rounding up into hidden=1 gets exponent 1.
- Stage 3, pack, priority highest first:
  1. nan | invalid: 0x7FF8_0000_0000_0000 | fls[51:0], sign 0. Always quiet.
  2. inf: {ss, 0x7FF, 0}.
  3. zero: exact zero. Sign = ss if the zero flag is from the input, else (RM==11). Exponent and fraction 0.
  4. exponent ≥ 2047: overflow.
     - RM 00 → inf.
     - RM 01 → max finite 0x7FEF_FFFF_FFFF_FFFF with sign.
     - RM 10 → +inf if positive else -max.
     - RM 11 → -inf if negative else +max.
  5. hidden=0: exponent field 0 (denormal).
  6. Otherwise: {sign, exp[10:0], frac}.
- Stall: while out_valid & !out_ready, result holds stable and in_ready=0.
- Reset mid-operation: in-flight beats are discarded; no output is produced for them.
- RM is sampled with the beat in stage 1 and carried down the pipe. A later RM change does not affect in-flight beats.

Optional Feature:
- Macro: FP_ROUND_EXC_EN.
- Defined: adds output `exc[3:0]` = {invalid, overflow, underflow, inexact}, aligned with result and held during stall. Reset value 0.
  - Inexact = g|s before rounding, or overflow.
  - Underflow = tiny after rounding and inexact.
- Undefined: no `exc` port and no flag logic.

Test Plan:
- 3.0+3.0 adder output: ss=0, es=0x400, fs[56:55]=2'b11, rest 0, RM=00 → result 0x4018_0000_0000_0000 on cycle 3.
- Tie rounding: es=0x3FF, fs hidden=1, fraction=0, guard=1, round=sticky=0, RM=00 → 0x3FF0_0000_0000_0000. Same with fraction lsb=1 → 0x3FF0_0000_0000_0002.
- Overflow: es=0x7FE, fs[56]=1, ss=0: RM=00 → 0x7FF0_0000_0000_0000; RM=01 → 0x7FEF_FFFF_FFFF_FFFF.
- Specials:
  - fls[55]=1, payload 0x1234 → 0x7FF8_0000_0000_1234.
  - fs=0, no flags, RM=11 → 0x8000_0000_0000_0000.
  - Same with RM=00 → 0x0.
- Backpressure: stream 5 beats with out_ready low cycles 4-6 → in_ready=0 those cycles, result stable, all 5 results in order, no loss or duplicate.
- Reset mid-flight: assert rst with 2 beats in pipe → out_valid=0 the next cycle; result=0; no stale output after rst releases.
